// File: rtl/acc_tx_pkg.sv
// acc_tx_pkg: shared constants and state encoding for the accumulator dump
// transmitter. Optional feature macro: ACC_TX_PARITY_EN (adds an even-parity
// bit to every frame and the ST_PARITY state).
package acc_tx_pkg;

  localparam int SB_TICK_DEF = 16;  // baud ticks per serial bit
  localparam int BYTE_W      = 8;   // width of one transmitted byte
  localparam int DATA_BITS   = 8;   // data bits per frame

  // Serializer states; ST_PARITY only exists in the parity build.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef ACC_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  // Counter width helper; never returns zero so a 1-count counter still has a bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Even parity over one byte (XOR of all data bits).
  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/acc_tx_uart_byte_tx.sv
// uart_byte_tx: serializes one byte as an 8N1 frame (8E1 when
// ACC_TX_PARITY_EN is defined), counting SB_TICK baud ticks per bit.
// A new byte can be loaded in IDLE or on the final tick of the stop bit,
// which lets the caller chain bytes with no idle gap.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   ST_IDLE   | line idle (tx=1), ticks ignored, waiting for load
//   ST_START  | start bit (tx=0)
//   ST_DATA   | data bits, LSB first (tx=shreg_q[0])
//   ST_PARITY | even-parity bit (parity build only)
//   ST_STOP   | stop bit (tx=1); last tick either reloads or idles
module uart_byte_tx
  import acc_tx_pkg::*;
#(
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              load,
  input  logic [BYTE_W-1:0] din,
  output logic              tx,
  output logic              stop_end
);

  localparam int TW = cnt_width(SB_TICK);
  localparam int CW = cnt_width(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(SB_TICK - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic              bit_end;
  logic              take;
`ifdef ACC_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
`ifdef ACC_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
`ifdef ACC_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Next-state, tick counting, bit sequencing and byte (re)load.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
`ifdef ACC_TX_PARITY_EN
    par_d      = par_q;
`endif

    bit_end  = (state_q != ST_IDLE) && tick && (tick_cnt_q == TICK_LAST);
    stop_end = (state_q == ST_STOP) && bit_end;
    take     = load && ((state_q == ST_IDLE) || stop_end);

    if ((state_q != ST_IDLE) && tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef ACC_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef ACC_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A load starts a fresh frame with a cleared tick counter; on the last
    // stop tick it overrides the return to IDLE so bytes go back to back.
    if (take) begin
      state_d    = ST_START;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      shreg_d    = din;
`ifdef ACC_TX_PARITY_EN
      par_d      = even_parity(din);
`endif
    end
  end

  // Line level is a pure function of the registered state, so it changes
  // on the same edge as the state.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shreg_q[0];
`ifdef ACC_TX_PARITY_EN
      ST_PARITY: tx = par_q;
`endif
      default:   tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_tx.sv
// acc_tx: dumps a DB-bit accumulator word over a UART line as DB/8 bytes,
// least significant byte first. Owns the shadow capture, byte sequencing,
// Busy and Done; the per-byte framing lives in uart_byte_tx.
// Optional feature macro: ACC_TX_PARITY_EN (even-parity bit per frame).
// DB must be a non-zero multiple of 8.
module acc_tx
  import acc_tx_pkg::*;
#(
  parameter int DB      = 16,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DB-1:0] Entrada,
  input  logic          Start,
  input  logic          tick,
  output logic          tx,
  output logic          Busy,
  output logic          Done
);

  localparam int NB = DB / BYTE_W;
  localparam int BW = cnt_width(NB);
  localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

  logic [DB-1:0]     shadow_q;
  logic [BW-1:0]     byte_idx_q;
  logic [BW-1:0]     next_idx;
  logic              busy_q;
  logic              done_q;
  logic              accept;
  logic              last_byte;
  logic              load;
  logic [BYTE_W-1:0] din;
  logic              stop_end;

  // Accept/advance decisions. The first byte is taken straight from Entrada
  // because the shadow register only holds the word after this edge.
  always_comb begin
    accept    = Start && !busy_q;
    last_byte = (byte_idx_q == LAST_IDX);
    next_idx  = byte_idx_q + 1'b1;
    load      = accept || (busy_q && stop_end && !last_byte);
    din       = accept ? Entrada[BYTE_W-1:0]
                       : shadow_q[{next_idx, 3'b000} +: BYTE_W];
  end

  // Shadow capture, byte index, Busy and the one-cycle Done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= '0;
      byte_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        shadow_q   <= Entrada;
        byte_idx_q <= '0;
        busy_q     <= 1'b1;
      end else if (busy_q && stop_end) begin
        if (last_byte) begin
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          byte_idx_q <= '0;
        end else begin
          byte_idx_q <= next_idx;
        end
      end
    end
  end

  uart_byte_tx #(
    .SB_TICK (SB_TICK)
  ) u_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (load),
    .din      (din),
    .tx       (tx),
    .stop_end (stop_end)
  );

  assign Busy = busy_q;
  assign Done = done_q;

endmodule
